vga_timing_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator. It is the successor to the fixed 640x480 controller in the board demo top level. It runs on the master clock with an internal pixel-enable divider, so no derived display clock is needed. Resolution, porches, sync widths and sync polarities are set by parameters. It exports pixel counters, active-video and frame-start strobes for downstream pixel sources, and drives 3-3-2 RGB from a runtime-selectable built-in pattern.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_pattern.sv | 35 +++
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 tb/tb_vga_timing_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared mode encodings, 3-3-2 colour constants and the colour-bar lookup.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,
        MODE_CHECK  = 2'd1,
        MODE_SOLID  = 2'd2,
        MODE_BORDER = 2'd3
    } mode_e;

    localparam logic [7:0] WHITE   = 8'hFF;
    localparam logic [7:0] YELLOW  = 8'hFC;
    localparam logic [7:0] CYAN    = 8'h1F;
    localparam logic [7:0] GREEN   = 8'h1C;
    localparam logic [7:0] MAGENTA = 8'hE3;
    localparam logic [7:0] RED     = 8'hE0;
    localparam logic [7:0] BLUE    = 8'h03;
    localparam logic [7:0] BLACK   = 8'h00;

    // Colour of bar idx, left to right across the active width.
    function automatic logic [7:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = WHITE;
            3'd1:    bar_color = YELLOW;
            3'd2:    bar_color = CYAN;
            3'd3:    bar_color = GREEN;
            3'd4:    bar_color = MAGENTA;
            3'd5:    bar_color = RED;
            3'd6:    bar_color = BLUE;
            default: bar_color = BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_pattern.sv
// Combinational test-pattern source: colour for a given pixel position and mode.
// Active-area blanking is applied by the caller.
module vga_pattern
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CW       = 10
) (
    input  logic [CW-1:0] hpos,
    input  logic [CW-1:0] vpos,
    input  logic [1:0]    mode,
    input  logic [7:0]    solid_rgb,
    output logic [7:0]    rgb
);

    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [CW-1:0] bar_idx;

    // Select the pattern colour; positions past the eighth bar fall back to black.
    always_comb begin
        rgb     = BLACK;
        bar_idx = hpos / CW'(BAR_W);
        case (mode)
            MODE_BARS:   rgb = (bar_idx > CW'(7)) ? BLACK : bar_color(bar_idx[2:0]);
            MODE_CHECK:  rgb = (hpos[5] ^ vpos[5]) ? WHITE : BLACK;
            MODE_SOLID:  rgb = solid_rgb;
            MODE_BORDER: rgb = (hpos == '0 || hpos == CW'(H_ACTIVE - 1) ||
                                vpos == '0 || vpos == CW'(V_ACTIVE - 1)) ? WHITE : BLACK;
            default:     rgb = BLACK;
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a pixel-enable divider on the master
// clock. All outputs are registered from the next counter values so syncs,
// active and colour line up with hcount/vcount.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = 2,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 10
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [1:0]    mode,
    input  logic [7:0]    solid_rgb,
    output logic          pix_en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          active,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic [2:0]    red,
    output logic [2:0]    green,
    output logic [1:0]    blue
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DW       = 4;

    logic [DW-1:0] div_q, div_d;
    logic          pix_en_q, pix_en_d;
    logic [CW-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic [1:0]    mode_q, mode_d;
    logic          active_q, active_d, fs_q, fs_d, hs_q, hs_d, vs_q, vs_d;
    logic [7:0]    rgb_q, rgb_d, pat_rgb;
    logic [CW-1:0] h_nxt, v_nxt;
    logic          active_nxt, wrap_nxt;

    // Divider, next raster position and the mode that applies to it.
    always_comb begin
        div_d    = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
        pix_en_d = (div_d == DW'(CLK_DIV - 1));
        h_nxt    = (hcount_q == CW'(H_TOTAL - 1)) ? '0 : hcount_q + 1'b1;
        v_nxt    = vcount_q;
        if (hcount_q == CW'(H_TOTAL - 1))
            v_nxt = (vcount_q == CW'(V_TOTAL - 1)) ? '0 : vcount_q + 1'b1;
        active_nxt = (h_nxt < CW'(H_ACTIVE)) && (v_nxt < CW'(V_ACTIVE));
        wrap_nxt   = pix_en_q && (h_nxt == '0) && (v_nxt == '0);
        // The new mode already governs the first pixel of the new frame.
        mode_d     = wrap_nxt ? mode : mode_q;
    end

    vga_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CW       (CW)
    ) u_pattern (
        .hpos      (h_nxt),
        .vpos      (v_nxt),
        .mode      (mode_d),
        .solid_rgb (solid_rgb),
        .rgb       (pat_rgb)
    );

    // Output next-state: everything holds except on pixel-enable clocks.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        active_d = active_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        rgb_d    = rgb_q;
        fs_d     = 1'b0;
        if (pix_en_q) begin
            hcount_d = h_nxt;
            vcount_d = v_nxt;
            active_d = active_nxt;
            hs_d     = (h_nxt >= CW'(HS_START) && h_nxt <= CW'(HS_END)) ? HS_POL : ~HS_POL;
            vs_d     = (v_nxt >= CW'(VS_START) && v_nxt <= CW'(VS_END)) ? VS_POL : ~VS_POL;
            rgb_d    = active_nxt ? pat_rgb : BLACK;
            fs_d     = wrap_nxt;
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            mode_q   <= '0;
            active_q <= 1'b0;
            fs_q     <= 1'b0;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
            rgb_q    <= BLACK;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            mode_q   <= mode_d;
            active_q <= active_d;
            fs_q     <= fs_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            rgb_q    <= rgb_d;
        end
    end

    assign pix_en      = pix_en_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign active      = active_q;
    assign frame_start = fs_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign red         = rgb_q[7:5];
    assign green       = rgb_q[4:2];
    assign blue        = rgb_q[1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a reduced-raster CLK_DIV=2 instance (A)
// and a tiny CLK_DIV=1 instance with positive syncs (B).
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int LIM = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vec    = 0;
    int miscmp = 0;

    // Instance A: 80x48 total, 64x40 active, hsync 68..75, vsync 42..43.
    logic       clr_a, pe_a, act_a, fs_a, hs_a, vs_a;
    logic [1:0] mode_a;
    logic [7:0] solid_a, rgb_a;
    logic [9:0] hc_a, vc_a;
    logic [2:0] r_a, g_a;
    logic [1:0] b_a;
    assign rgb_a = {r_a, g_a, b_a};

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(10)
    ) dut_a (
        .clk(clk), .clr(clr_a), .mode(mode_a), .solid_rgb(solid_a),
        .pix_en(pe_a), .hcount(hc_a), .vcount(vc_a), .active(act_a),
        .frame_start(fs_a), .hsync(hs_a), .vsync(vs_a),
        .red(r_a), .green(g_a), .blue(b_a)
    );

    // Instance B: 22x7 total, 16x4 active, hsync 18..19, vsync line 5, active-high syncs.
    logic       clr_b, pe_b, act_b, fs_b, hs_b, vs_b;
    logic [1:0] mode_b;
    logic [7:0] solid_b, rgb_b;
    logic [9:0] hc_b, vc_b;
    logic [2:0] r_b, g_b;
    logic [1:0] b_b;
    assign rgb_b = {r_b, g_b, b_b};

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(10)
    ) dut_b (
        .clk(clk), .clr(clr_b), .mode(mode_b), .solid_rgb(solid_b),
        .pix_en(pe_b), .hcount(hc_b), .vcount(vc_b), .active(act_b),
        .frame_start(fs_b), .hsync(hs_b), .vsync(vs_b),
        .red(r_b), .green(g_b), .blue(b_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vec++;
        miscmp++;
        $error("FAIL %s: wait expired after %0d clks", tag, LIM);
    endtask

    // Step negedges until the selected instance sits at (h,v).
    task automatic wait_pos(input bit sel, input int h, input int v);
        int n;
        n = 0;
        while (!((sel ? int'(hc_b) : int'(hc_a)) == h &&
                 (sel ? int'(vc_b) : int'(vc_a)) == v) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) timeout($sformatf("wait_pos_%0d_%0d", h, v));
    endtask

    // Advance to the next frame_start of instance A; n is clks waited.
    task automatic wait_fs_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_a && n < LIM);
        if (n >= LIM) timeout("wait_frame_start");
    endtask

    initial begin
        int n, cnt, vmin, vmax;
        logic prev;

        clr_a = 1'b1; clr_b = 1'b1;
        mode_a = 2'd0; mode_b = 2'd0;
        solid_a = 8'h00; solid_b = 8'h00;

        // Reset values while clr is held.
        repeat (5) @(negedge clk);
        check("rst_pix_en", pe_a, 0);
        check("rst_hcount", hc_a, 0);
        check("rst_vcount", vc_a, 0);
        check("rst_active", act_a, 0);
        check("rst_frame_start", fs_a, 0);
        check("rst_hsync", hs_a, 1);
        check("rst_vsync", vs_a, 1);
        check("rst_rgb", rgb_a, 8'h00);

        // First pixel enable and first advance after release.
        clr_a = 1'b0;
        @(negedge clk);
        check("rel1_pix_en", pe_a, 1);
        check("rel1_hcount", hc_a, 0);
        @(negedge clk);
        check("rel2_pix_en", pe_a, 0);
        check("rel2_hcount", hc_a, 1);
        check("rel2_active", act_a, 1);
        check("rel2_rgb_white", rgb_a, 8'hFF);

        // Line timing: hsync falling edge position and period.
        n = 0;
        do begin prev = hs_a; @(negedge clk); n++; end while (!(prev && !hs_a) && n < LIM);
        check("hs_fall_hcount", hc_a, 68);
        check("hs_fall_vcount", vc_a, 0);
        n = 0; cnt = 0;
        do begin
            if (!hs_a && pe_a) cnt++;
            prev = hs_a;
            @(negedge clk);
            n++;
        end while (!(prev && !hs_a) && n < LIM);
        check("line_period_clks", n, 160);
        check("hs_low_pixels", cnt, 8);

        // Frame timing: spacing, active pixel count and vsync lines.
        wait_fs_a(n);
        check("fs_hcount", hc_a, 0);
        check("fs_vcount", vc_a, 0);
        n = 0; cnt = 0; vmin = 999; vmax = -1;
        do begin
            if (pe_a && act_a) cnt++;
            if (!vs_a) begin
                if (int'(vc_a) < vmin) vmin = int'(vc_a);
                if (int'(vc_a) > vmax) vmax = int'(vc_a);
            end
            @(negedge clk);
            n++;
        end while (!fs_a && n < LIM);
        check("frame_period_clks", n, 7680);
        check("active_pixels", cnt, 2560);
        check("vs_first_line", vmin, 42);
        check("vs_last_line", vmax, 43);

        // Mode change mid-frame waits for the next frame_start.
        wait_pos(0, 0, 10);
        mode_a = 2'd2; solid_a = 8'hE0;
        wait_pos(0, 9, 20);
        check("bars_hold_yellow", rgb_a, 8'hFC);
        wait_fs_a(n);
        check("solid_at_fs_red", r_a, 7);
        check("solid_at_fs_green", g_a, 0);
        check("solid_at_fs_blue", b_a, 0);
        mode_a = 2'd3;
        wait_pos(0, 1, 1);
        check("solid_hold", rgb_a, 8'hE0);

        // Border pattern.
        wait_fs_a(n);
        check("border_0_0", rgb_a, 8'hFF);
        wait_pos(0, 1, 1);
        check("border_1_1", rgb_a, 8'h00);
        wait_pos(0, 63, 20);
        check("border_63_20", rgb_a, 8'hFF);
        wait_pos(0, 64, 20);
        check("porch_rgb", rgb_a, 8'h00);
        check("porch_active", act_a, 0);
        wait_pos(0, 32, 39);
        check("border_32_39", rgb_a, 8'hFF);

        // Checkerboard pattern.
        mode_a = 2'd1;
        wait_fs_a(n);
        wait_pos(0, 5, 5);
        check("check_5_5", rgb_a, 8'h00);
        wait_pos(0, 33, 5);
        check("check_33_5", rgb_a, 8'hFF);
        wait_pos(0, 5, 33);
        check("check_5_33", rgb_a, 8'hFF);
        wait_pos(0, 33, 33);
        check("check_33_33", rgb_a, 8'h00);

        // Colour bars.
        mode_a = 2'd0;
        wait_fs_a(n);
        wait_pos(0, 24, 5);
        check("bar3_green", rgb_a, 8'h1C);
        wait_pos(0, 40, 5);
        check("bar5_red", rgb_a, 8'hE0);
        wait_pos(0, 56, 5);
        check("bar7_black", rgb_a, 8'h00);
        wait_pos(0, 64, 5);
        check("bar_porch_black", rgb_a, 8'h00);

        // Instance B: reset values with active-high sync polarity.
        check("b_rst_pix_en", pe_b, 0);
        check("b_rst_hsync", hs_b, 0);
        check("b_rst_vsync", vs_b, 0);
        clr_b = 1'b0;
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (pe_b) cnt++;
            @(negedge clk);
        end
        check("b_pix_en_continuous", cnt, 30);
        wait_pos(1, 18, 1);
        check("b_hsync_on", hs_b, 1);
        wait_pos(1, 20, 1);
        check("b_hsync_off", hs_b, 0);
        wait_pos(1, 21, 1);
        @(negedge clk);
        check("b_wrap_hcount", hc_b, 0);
        check("b_wrap_vcount", vc_b, 2);
        wait_pos(1, 3, 2);
        check("b_bar1_yellow", rgb_b, 8'hFC);
        wait_pos(1, 0, 5);
        check("b_vsync_on", vs_b, 1);
        check("b_vblank_active", act_b, 0);

        // Clear asserted mid-line.
        wait_pos(1, 7, 3);
        clr_b = 1'b1;
        @(negedge clk);
        check("b_clr_hcount", hc_b, 0);
        check("b_clr_vcount", vc_b, 0);
        check("b_clr_pix_en", pe_b, 0);
        check("b_clr_active", act_b, 0);
        check("b_clr_hsync", hs_b, 0);
        check("b_clr_rgb", rgb_b, 8'h00);
        check("b_clr_fs", fs_b, 0);
        clr_b = 1'b0;
        @(negedge clk);
        check("b_rel1_pix_en", pe_b, 1);
        check("b_rel1_hcount", hc_b, 0);
        @(negedge clk);
        check("b_rel2_hcount", hc_b, 1);
        check("b_rel2_rgb", rgb_b, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
